// File: rtl/test_port_capture_if.sv
`default_nettype none
// test_port_capture_if: data-memory write snoop bus plus valid/ready capture stream
// Rev 1.0
interface test_port_capture_if;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output addr, data, wen, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  addr, data, wen, out_ready,
    output out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/test_port_capture.sv
`default_nettype none
// test_port_capture: framed test-port store capture into a valid/ready FIFO.
// Rev 1.0 -- TPC_DEDUP_EN collapses stall-repeated writes into one event.
module test_port_capture #(
  parameter logic [29:0] TEST_PORT  = 30'h10,
  parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
  parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  test_port_capture_if.slave        bus,
  output logic                      armed,
  output logic                      done,
  output logic                      overflow,
  output logic [7:0]                word_cnt,
  output logic [15:0]               cycle_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] swap;
  logic        hit;
  logic        ev;
  logic        push;

  assign swap = {bus.data[7:0], bus.data[15:8], bus.data[23:16], bus.data[31:24]};
  assign hit  = bus.wen && (bus.addr == TEST_PORT);

`ifdef TPC_DEDUP_EN
  logic hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit;
  end

  assign ev = hit && !hit_q;
`else
  assign ev = hit;
`endif

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev && swap == BEGIN_SYM) state_d = ARMED;
      end
      ARMED: begin
        if (ev) begin
          push = 1'b1;
          if (swap == END_SYM) state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign armed = (state_q == ARMED);
  assign done  = (state_q == DONE);

  // FIFO: one extra pointer bit distinguishes full from empty
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, do_push, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign pop     = !empty && bus.out_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= swap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      word_cnt  <= 8'h00;
      cycle_cnt <= 16'h0000;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)    overflow <= 1'b1;
      if (do_push && word_cnt != 8'hFF) word_cnt <= word_cnt + 8'h01;
      if (state_q == ARMED && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'h0001;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_test_port_capture.sv
`default_nettype none
// tb_test_port_capture: directed self-checking bench for test_port_capture.
// Rev 1.0
module tb_test_port_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        armed, done, overflow;
  logic [7:0]  word_cnt;
  logic [15:0] cycle_cnt;

  test_port_capture_if bus_if ();

  test_port_capture dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .armed     (armed),
    .done      (done),
    .overflow  (overflow),
    .word_cnt  (word_cnt),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] got [$];

  localparam logic [31:0] BEGIN_LE = 32'h68010000;
  localparam logic [31:0] END_RD   = 32'hFFFFFD5D;

  always @(negedge clk) begin
    if (!rst && bus_if.out_valid && bus_if.out_ready) got.push_back(bus_if.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] le(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [29:0] a, input logic [31:0] d);
    tick();
    bus_if.addr = a;
    bus_if.data = d;
    bus_if.wen  = 1'b1;
    tick();
    bus_if.wen  = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_stall;
    rst              = 1'b1;
    bus_if.addr      = '0;
    bus_if.data      = '0;
    bus_if.wen       = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", {31'b0, bus_if.out_valid}, 32'd0);
    check("rst_data", bus_if.out_data, 32'd0);
    check("rst_armed", {31'b0, armed}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_wcnt", {24'b0, word_cnt}, 32'd0);
    check("rst_ccnt", {16'b0, cycle_cnt}, 32'd0);
    rst = 1'b0;

    // IDLE ignores non-begin words
    store(30'h10, le(32'h12345678));
    tick();
    check("idle_armed", {31'b0, armed}, 32'd0);
    check("idle_valid", {31'b0, bus_if.out_valid}, 32'd0);

    // Arm, three words, end
    bus_if.out_ready = 1'b1;
    store(30'h10, BEGIN_LE);
    check("t1_armed", {31'b0, armed}, 32'd1);
    store(30'h10, le(32'h0000CCCC));
    store(30'h10, le(32'h00008763));
    store(30'h10, le(END_RD));
    repeat (4) tick();
    check("t1_n", got.size(), 32'd3);
    check("t1_w0", got[0], 32'h0000CCCC);
    check("t1_w1", got[1], 32'h00008763);
    check("t1_w2", got[2], END_RD);
    check("t1_wcnt", {24'b0, word_cnt}, 32'd3);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_armed_off", {31'b0, armed}, 32'd0);
    check("t1_ovf", {31'b0, overflow}, 32'd0);
    check("t1_ccnt", {16'b0, cycle_cnt}, 32'd6);

    // DONE ignores further events and freezes the cycle count
    store(30'h10, le(32'h0000ABCD));
    repeat (3) tick();
    check("done_n", got.size(), 32'd3);
    check("done_wcnt", {24'b0, word_cnt}, 32'd3);
    check("done_ccnt", {16'b0, cycle_cnt}, 32'd6);

    // Overflow with a stalled consumer; off-port write ignored
    do_reset();
    bus_if.out_ready = 1'b0;
    store(30'h10, BEGIN_LE);
    store(30'h11, le(32'hBAD00BAD));
    for (int i = 1; i <= 5; i++) store(30'h10, le(32'h000000A0 + i));
    tick();
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    check("ovf_wcnt", {24'b0, word_cnt}, 32'd4);
    check("ovf_head", bus_if.out_data, 32'h000000A1);
    bus_if.out_ready = 1'b1;
    repeat (6) tick();
    check("ovf_n", got.size(), 32'd4);
    check("ovf_w0", got[0], 32'h000000A1);
    check("ovf_w3", got[3], 32'h000000A4);
    check("ovf_empty", {31'b0, bus_if.out_valid}, 32'd0);

    // Full FIFO with push and pop in the same cycle
    do_reset();
    bus_if.out_ready = 1'b0;
    store(30'h10, BEGIN_LE);
    for (int i = 1; i <= 4; i++) store(30'h10, le(32'h000000B0 + i));
    tick();
    bus_if.addr      = 30'h10;
    bus_if.data      = le(32'h000000B5);
    bus_if.wen       = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.wen       = 1'b0;
    bus_if.out_ready = 1'b0;
    check("fp_ovf", {31'b0, overflow}, 32'd0);
    check("fp_wcnt", {24'b0, word_cnt}, 32'd5);
    check("fp_head", bus_if.out_data, 32'h000000B2);
    bus_if.out_ready = 1'b1;
    repeat (6) tick();
    check("fp_n", got.size(), 32'd5);
    check("fp_w0", got[0], 32'h000000B1);
    check("fp_w4", got[4], 32'h000000B5);

    // Asynchronous reset mid-run
    do_reset();
    bus_if.out_ready = 1'b0;
    store(30'h10, BEGIN_LE);
    store(30'h10, le(32'h000000C1));
    store(30'h10, le(32'h000000C2));
    tick();
    #1 rst = 1'b1;
    #1;
    check("mr_valid", {31'b0, bus_if.out_valid}, 32'd0);
    check("mr_armed", {31'b0, armed}, 32'd0);
    check("mr_wcnt", {24'b0, word_cnt}, 32'd0);
    check("mr_ccnt", {16'b0, cycle_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    got.delete();
    store(30'h10, le(32'h00005555));
    check("mr_noarm", {31'b0, armed}, 32'd0);
    store(30'h10, BEGIN_LE);
    check("mr_rearm", {31'b0, armed}, 32'd1);
    check("mr_empty", {31'b0, bus_if.out_valid}, 32'd0);

    // Store held across five stall cycles
    do_reset();
    bus_if.out_ready = 1'b1;
    store(30'h10, BEGIN_LE);
    tick();
    bus_if.addr = 30'h10;
    bus_if.data = le(32'h66660000);
    bus_if.wen  = 1'b1;
    repeat (5) tick();
    bus_if.wen  = 1'b0;
    repeat (6) tick();
`ifdef TPC_DEDUP_EN
    n_stall = 1;
`else
    n_stall = 5;
`endif
    check("st_wcnt", {24'b0, word_cnt}, n_stall);
    check("st_n", got.size(), n_stall);
    check("st_w0", got[0], 32'h66660000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
